// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN weight path.
// Holds the default geometry (element width, array dimension, width of the
// size/index fields), the row-shifter FSM state encoding, and the flattened
// weight-matrix element offset used by both weight_fill_control and
// weight_row_shifter so the two agree on the layout of the snapshot bus.
package cnn_pkg;

    localparam int default_data_size     = 8;
    localparam int default_array_size    = 9;
    localparam int default_dim_data_size = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Bit offset of element (r,c) in a flattened n x n matrix of w-bit elements.
    function automatic int elem_offset(input int r, input int c,
                                       input int n = default_array_size,
                                       input int w = default_data_size);
        return (r * n + c) * w;
    endfunction

endpackage

// File: rtl/weight_row_shifter.sv
// weight_row_shifter
// Takes the flattened weight snapshot produced by weight_fill_control and
// streams it into the systolic array one row per accepted beat, bottom row
// first, so that after array_size beats every PE row holds its own weights.
// Rows and columns at or beyond the active kernel size k are zeroed. After the
// last beat a one-cycle load_weights strobe is issued, then a one-cycle done.
// An illegal k (0 or larger than the array) skips straight to done+size_err.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   fill_done    rising edge starts a transfer (ignored while busy)
//   weight_in    snapshot, element (r,c) at elem_offset(r,c)
//   weight_size  kernel dimension k, captured with weight_in
//   array_ready  array accepts row_out this cycle
//   row_out      current row, column c at [c*data_size +: data_size]
//   row_valid    row_out is valid
//   row_index    source row on row_out (0 when not valid)
//   load_weights one-cycle strobe after the last beat
//   busy         transfer in progress
//   done         one-cycle completion pulse
//   size_err     one-cycle pulse with done when k was illegal
module weight_row_shifter
    import cnn_pkg::*;
#(
    parameter int data_size     = default_data_size,
    parameter int array_size    = default_array_size,
    parameter int dim_data_size = default_dim_data_size
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        fill_done,
    input  logic [array_size*array_size*data_size-1:0]  weight_in,
    input  logic [dim_data_size-1:0]                    weight_size,
    input  logic                                        array_ready,
    output logic [array_size*data_size-1:0]             row_out,
    output logic                                        row_valid,
    output logic [dim_data_size-1:0]                    row_index,
    output logic                                        load_weights,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        size_err
);

    localparam int idx_w = (array_size > 1) ? $clog2(array_size) : 1;
    localparam int row_w = array_size * data_size;
    localparam int mat_w = array_size * row_w;

    state_t                   state_reg, state_next;
    logic [idx_w-1:0]         row_cnt_reg, row_cnt_next;
    logic [dim_data_size-1:0] k_reg, k_next;
    logic [mat_w-1:0]         shadow_reg, shadow_next;
    logic                     err_reg, err_next;
    logic                     fill_done_q;

    logic start;
    logic k_bad;
    assign start = fill_done & ~fill_done_q;
    assign k_bad = (weight_size == '0) || (weight_size > dim_data_size'(array_size));

    // ---------------- row select and mask ----------------
    logic [row_w-1:0] rows [array_size];
    logic [row_w-1:0] sel_row;
    logic             row_en;

    genvar gi;
    generate
        for (gi = 0; gi < array_size; gi++) begin : g_rows
            assign rows[gi] = shadow_reg[elem_offset(gi, 0, array_size, data_size) +: row_w];
        end
    endgenerate

    assign sel_row = rows[row_cnt_reg];
    // Whole row is blanked once the row number reaches k; this also keeps
    // row_out at zero whenever row_valid is low.
    assign row_en  = row_valid && (dim_data_size'(row_cnt_reg) < k_reg);

    generate
        for (gi = 0; gi < array_size; gi++) begin : g_cols
            assign row_out[gi*data_size +: data_size] =
                (row_en && (k_reg > dim_data_size'(gi))) ? sel_row[gi*data_size +: data_size]
                                                         : '0;
        end
    endgenerate

    assign row_index = row_valid ? dim_data_size'(row_cnt_reg) : '0;
    assign busy      = (state_reg != IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            row_cnt_reg <= '0;
            k_reg       <= '0;
            shadow_reg  <= '0;
            err_reg     <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            state_reg   <= state_next;
            row_cnt_reg <= row_cnt_next;
            k_reg       <= k_next;
            shadow_reg  <= shadow_next;
            err_reg     <= err_next;
            fill_done_q <= fill_done;
        end
    end

    always_comb begin
        state_next   = state_reg;
        row_cnt_next = row_cnt_reg;
        k_next       = k_reg;
        shadow_next  = shadow_reg;
        err_next     = err_reg;
        row_valid    = 1'b0;
        load_weights = 1'b0;
        done         = 1'b0;
        size_err     = 1'b0;
        case (state_reg)
            IDLE: begin
                err_next = 1'b0;
                if (start) begin
                    shadow_next = weight_in;
                    k_next      = weight_size;
                    if (k_bad) begin
                        err_next   = 1'b1;
                        state_next = FIN;
                    end else begin
                        row_cnt_next = idx_w'(array_size - 1);
                        state_next   = SHIFT;
                    end
                end
            end
            SHIFT: begin
                row_valid = 1'b1;
                if (array_ready) begin
                    if (row_cnt_reg == '0) begin
                        state_next = LOAD;
                    end else begin
                        row_cnt_next = row_cnt_reg - 1'b1;
                    end
                end
            end
            LOAD: begin
                load_weights = 1'b1;
                state_next   = FIN;
            end
            FIN: begin
                done       = 1'b1;
                size_err   = err_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_weight_row_shifter.sv
module tb_weight_row_shifter;

    localparam int DS  = 8;
    localparam int AS  = 9;
    localparam int DDS = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   fill_done;
    logic [AS*AS*DS-1:0]    weight_in;
    logic [DDS-1:0]         weight_size;
    logic                   array_ready;
    logic [AS*DS-1:0]       row_out;
    logic                   row_valid;
    logic [DDS-1:0]         row_index;
    logic                   load_weights;
    logic                   busy;
    logic                   done;
    logic                   size_err;

    weight_row_shifter #(.data_size(DS), .array_size(AS), .dim_data_size(DDS)) dut (
        .clk(clk), .reset(reset), .fill_done(fill_done), .weight_in(weight_in),
        .weight_size(weight_size), .array_ready(array_ready), .row_out(row_out),
        .row_valid(row_valid), .row_index(row_index), .load_weights(load_weights),
        .busy(busy), .done(done), .size_err(size_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference weights and kernel size
    int w [AS][AS];
    int k_model;

    // observations of one transfer
    logic [AS*DS-1:0] obs_rows[$];
    int               obs_idx[$];
    int n_valid, n_stall, n_load, load_cyc, n_done, done_cyc, n_err, n_unstable, n_idle_nz;

    // Expected row r: weight kept only inside the k x k kernel window.
    function automatic logic [AS*DS-1:0] expected_row(input int r);
        logic [AS*DS-1:0] v;
        v = '0;
        for (int c = 0; c < AS; c++)
            if (r < k_model && c < k_model) v[c*DS +: DS] = DS'(w[r][c]);
        return v;
    endfunction

    task automatic apply_weights();
        for (int r = 0; r < AS; r++)
            for (int c = 0; c < AS; c++)
                weight_in[(r*AS+c)*DS +: DS] = DS'(w[r][c]);
        weight_size = DDS'(k_model);
    endtask

    // Starts a transfer and records what the DUT does for ncyc cycles.
    // Cycle 1 is the first cycle after the edge that samples the start.
    task automatic observe(input int ncyc, input int fd_hold, input int glitch_cyc,
                           input int stall_row, input int stall_len, input bit rand_ready);
        logic [AS*DS-1:0] prev_row;
        int  prev_idx;
        bit  prev_stalled;
        int  stall_left;
        obs_rows.delete();
        obs_idx.delete();
        n_valid = 0; n_stall = 0; n_load = 0; load_cyc = -1; n_done = 0;
        done_cyc = -1; n_err = 0; n_unstable = 0; n_idle_nz = 0;
        stall_left = stall_len;
        prev_stalled = 0;
        prev_row = '0;
        prev_idx = 0;
        apply_weights();
        @(posedge clk); #1;
        fill_done = 1'b1;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(posedge clk); #1;
            fill_done = !(cyc >= fd_hold || cyc == glitch_cyc);
            if (row_valid && stall_left > 0 && int'(row_index) == stall_row) begin
                array_ready = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                array_ready = ($urandom_range(0, 2) != 0);
            end else begin
                array_ready = 1'b1;
            end
            @(negedge clk);
            if (prev_stalled && (row_out !== prev_row || int'(row_index) != prev_idx))
                n_unstable++;
            prev_stalled = row_valid && !array_ready;
            prev_row = row_out;
            prev_idx = int'(row_index);
            if (row_valid) begin
                n_valid++;
                if (array_ready) begin
                    obs_rows.push_back(row_out);
                    obs_idx.push_back(int'(row_index));
                end else begin
                    n_stall++;
                end
            end else if (row_out !== '0) begin
                n_idle_nz++;
            end
            if (load_weights) begin n_load++; load_cyc = cyc; end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                if (size_err) n_err++;
            end
        end
        fill_done = 1'b0;
        array_ready = 1'b1;
        $display("xfer k=%0d beats=%0d stalls=%0d load@%0d done@%0d size_err=%0d",
                 k_model, obs_rows.size(), n_stall, load_cyc, done_cyc, n_err);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        total++; if (row_valid !== 1'b0 || busy !== 1'b0 || load_weights !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl: valid=%b busy=%b load=%b required 0 0 0", row_valid, busy, load_weights);
        end
        total++; if (done !== 1'b0 || size_err !== 1'b0) begin
            bad++; $display("FAIL reset_done: done=%b size_err=%b required 0 0", done, size_err);
        end
        total++; if (row_out !== '0 || row_index !== '0) begin
            bad++; $display("FAIL reset_data: row_out=%h row_index=%0d required 0 0", row_out, row_index);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || row_valid !== 1'b0) begin
            bad++; $display("FAIL reset_idle: busy=%b valid=%b required 0 0", busy, row_valid);
        end
    endtask

    task automatic test_masked_k3(input int stall_len);
        int exp_done;
        logic [AS*DS-1:0] row2_exp, row0_exp;
        row2_exp = '0; row2_exp[23:0] = 24'h151413;
        row0_exp = '0; row0_exp[23:0] = 24'h030201;
        for (int r = 0; r < AS; r++)
            for (int c = 0; c < AS; c++) w[r][c] = r*9 + c + 1;
        k_model = 3;
        observe(20, 1, 0, 5, stall_len, 1'b0);
        exp_done = 11 + stall_len;
        for (int i = 0; i < AS; i++) begin
            total++;
            if (i >= obs_rows.size() || obs_rows[i] !== expected_row(AS-1-i) || obs_idx[i] != AS-1-i) begin
                bad++; $display("FAIL k3_beat%0d: got %h idx %0d required %h idx %0d", i,
                    (i < obs_rows.size()) ? obs_rows[i] : '0, (i < obs_idx.size()) ? obs_idx[i] : -1,
                    expected_row(AS-1-i), AS-1-i);
            end
        end
        total++; if (obs_rows.size() != AS) begin
            bad++; $display("FAIL k3_beats: got %0d required %0d", obs_rows.size(), AS);
        end
        total++; if (obs_rows.size() >= 9 && (obs_rows[6] !== row2_exp || obs_rows[8] !== row0_exp)) begin
            bad++; $display("FAIL k3_rows20: row2=%h row0=%h required %h %h", obs_rows[6], obs_rows[8], row2_exp, row0_exp);
        end
        total++; if (load_cyc != exp_done - 1 || n_load != 1) begin
            bad++; $display("FAIL k3_load: at %0d count %0d required at %0d count 1", load_cyc, n_load, exp_done-1);
        end
        total++; if (done_cyc != exp_done || n_done != 1 || n_err != 0) begin
            bad++; $display("FAIL k3_done: at %0d count %0d err %0d required at %0d count 1 err 0", done_cyc, n_done, n_err, exp_done);
        end
        total++; if (n_unstable != 0 || n_stall != stall_len) begin
            bad++; $display("FAIL k3_stall: unstable=%0d stalls=%0d required 0 %0d", n_unstable, n_stall, stall_len);
        end
        total++; if (n_idle_nz != 0) begin
            bad++; $display("FAIL k3_idle_zero: nonzero idle cycles=%0d required 0", n_idle_nz);
        end
    endtask

    task automatic test_full_ff();
        logic [AS*DS-1:0] ones;
        ones = '1;
        for (int r = 0; r < AS; r++)
            for (int c = 0; c < AS; c++) w[r][c] = 255;
        k_model = 9;
        observe(16, 1, 0, -1, 0, 1'b0);
        for (int i = 0; i < AS; i++) begin
            total++;
            if (i >= obs_rows.size() || obs_rows[i] !== ones) begin
                bad++; $display("FAIL ff_beat%0d: got %h required %h", i,
                    (i < obs_rows.size()) ? obs_rows[i] : '0, ones);
            end
        end
        total++; if (done_cyc != 11 || obs_rows.size() != AS) begin
            bad++; $display("FAIL ff_done: at %0d beats %0d required 11 %0d", done_cyc, obs_rows.size(), AS);
        end
    endtask

    task automatic test_bad_size();
        int sizes [2];
        sizes[0] = 0;
        sizes[1] = 10;
        for (int t = 0; t < 2; t++) begin
            k_model = sizes[t];
            observe(6, 1, 0, -1, 0, 1'b0);
            total++; if (done_cyc != 1 || n_done != 1 || n_err != 1) begin
                bad++; $display("FAIL badk%0d_done: at %0d count %0d err %0d required at 1 count 1 err 1", k_model, done_cyc, n_done, n_err);
            end
            total++; if (n_valid != 0 || n_load != 0) begin
                bad++; $display("FAIL badk%0d_quiet: valid=%0d load=%0d required 0 0", k_model, n_valid, n_load);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            for (int r = 0; r < AS; r++)
                for (int c = 0; c < AS; c++) w[r][c] = int'($urandom_range(0, 255));
            k_model = int'($urandom_range(1, 9));
            observe(60, 1, 0, -1, 0, 1'b1);
            for (int i = 0; i < AS; i++) begin
                total++;
                if (i >= obs_rows.size() || obs_rows[i] !== expected_row(AS-1-i) || obs_idx[i] != AS-1-i) begin
                    bad++; $display("FAIL rnd%0d_beat%0d: got %h required %h (k=%0d)", t, i,
                        (i < obs_rows.size()) ? obs_rows[i] : '0, expected_row(AS-1-i), k_model);
                end
            end
            total++; if (done_cyc != 11 + n_stall || load_cyc != done_cyc - 1 || n_load != 1 || n_done != 1) begin
                bad++; $display("FAIL rnd%0d_timing: done@%0d load@%0d loads=%0d dones=%0d required done@%0d", t,
                    done_cyc, load_cyc, n_load, n_done, 11 + n_stall);
            end
            total++; if (n_unstable != 0 || obs_rows.size() != AS) begin
                bad++; $display("FAIL rnd%0d_stable: unstable=%0d beats=%0d required 0 %0d", t, n_unstable, obs_rows.size(), AS);
            end
        end
    endtask

    task automatic test_hold();
        for (int r = 0; r < AS; r++)
            for (int c = 0; c < AS; c++) w[r][c] = int'($urandom_range(0, 255));
        k_model = 5;
        observe(45, 40, 5, -1, 0, 1'b0);
        total++; if (n_done != 1 || done_cyc != 11 || n_load != 1) begin
            bad++; $display("FAIL hold_once: dones=%0d done@%0d loads=%0d required 1 11 1", n_done, done_cyc, n_load);
        end
        total++; if (obs_rows.size() != AS || n_valid != AS) begin
            bad++; $display("FAIL hold_beats: beats=%0d valid=%0d required %0d %0d", obs_rows.size(), n_valid, AS, AS);
        end
    endtask

    task automatic test_reset_mid();
        int leak;
        for (int r = 0; r < AS; r++)
            for (int c = 0; c < AS; c++) w[r][c] = r*9 + c + 1;
        k_model = 9;
        apply_weights();
        @(posedge clk); #1;
        fill_done = 1'b1;
        @(posedge clk); #1;
        fill_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++; if (row_valid !== 1'b1 || int'(row_index) != 4) begin
            bad++; $display("FAIL rstmid_pre: valid=%b idx=%0d required 1 4", row_valid, row_index);
        end
        reset = 1'b1;
        #1;
        total++; if (row_valid !== 1'b0 || busy !== 1'b0 || load_weights !== 1'b0 || row_out !== '0) begin
            bad++; $display("FAIL rstmid_now: valid=%b busy=%b load=%b row=%h required 0 0 0 0", row_valid, busy, load_weights, row_out);
        end
        leak = 0;
        repeat (3) begin
            @(negedge clk);
            if (row_valid || busy || load_weights || done) leak++;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (row_valid || busy || load_weights || done) leak++;
        end
        total++; if (leak != 0) begin
            bad++; $display("FAIL rstmid_quiet: active cycles=%0d required 0", leak);
        end
        for (int r = 0; r < AS; r++)
            for (int c = 0; c < AS; c++) w[r][c] = int'($urandom_range(0, 255));
        observe(16, 1, 0, -1, 0, 1'b0);
        for (int i = 0; i < AS; i++) begin
            total++;
            if (i >= obs_rows.size() || obs_rows[i] !== expected_row(AS-1-i) || obs_idx[i] != AS-1-i) begin
                bad++; $display("FAIL rstmid_beat%0d: got %h required %h", i,
                    (i < obs_rows.size()) ? obs_rows[i] : '0, expected_row(AS-1-i));
            end
        end
        total++; if (done_cyc != 11 || n_load != 1) begin
            bad++; $display("FAIL rstmid_done: done@%0d loads=%0d required 11 1", done_cyc, n_load);
        end
    endtask

    initial begin
        reset       = 1'b1;
        fill_done   = 1'b0;
        array_ready = 1'b1;
        weight_in   = '0;
        weight_size = '0;
        k_model     = 0;
        repeat (2) @(posedge clk);
        test_reset();
        test_masked_k3(0);
        test_masked_k3(3);
        test_full_ff();
        test_bad_size();
        test_random();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
